counter8_seq: RTL and testbench

Command sequencer sitting directly upstream of `counter8`. Accepts opcode/argument commands over a valid/ready handshake and drives every control input of `counter8` (CLR, LOAD/DIN, HOLD, MODE_SEL, INC/DEC start/end) with registered, correctly spaced pulses. Timed runs are handled here, so software or a host FSM issues "count up for N cycles" rather than toggling individual strobes.

---
 rtl/counter8_seq.sv | 229 ++++++++++++++++++++++
 tb/tb_counter8_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter8_seq.sv
// counter8_seq -- command sequencer for counter8.
//
// Accepts opcode/argument commands over a valid/ready handshake and turns
// them into registered, correctly spaced control pulses for counter8.
// A timed run becomes a START strobe, ARG quiet cycles, then an END strobe.
//
// Optional feature: define COUNTER8_SEQ_FIFO_EN to place a 4-entry command
// FIFO between the handshake and the FSM. CMD_READY then means "FIFO not
// full", and BUSY also covers queued commands.
//
// Ports:
//   CLK, RESETn            clock (rising edge) and asynchronous active-low reset
//   CMD_VALID / CMD_READY  command handshake; accepted when both are high at an edge
//   CMD_OP[2:0]            0 NOP, 1 CLR, 2 LOAD, 3 RUN_INC, 4 RUN_DEC, 5 HOLD, 6 MODE, 7 illegal
//   CMD_ARG[7:0]           load value / cycle count / mode bit
//   CLR, LOAD              one-cycle pulses to counter8
//   DIN[7:0]               load data, held after the load
//   HOLD                   hold level, high for ARG cycles
//   MODE_SEL               counter mode select (resets to 1)
//   INC_START/INC_END      run strobes for RUN_INC
//   DEC_START/DEC_END      run strobes for RUN_DEC
//   BUSY                   command executing (or queued, with the FIFO)
//   ERR                    sticky illegal-opcode flag, cleared only by reset
//
// Structure: a control FSM (state, wait counter, latched command) runs one
// cycle ahead of the output registers, which decode the FSM state at every
// edge. That gives the one-cycle accept-to-output latency, and because the
// FSM can take the next command in its last cycle, commands run with no
// gap between them.

module counter8_seq (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [2:0] CMD_OP,
  input  logic [7:0] CMD_ARG,
  output logic       CLR,
  output logic       LOAD,
  output logic [7:0] DIN,
  output logic       HOLD,
  output logic       MODE_SEL,
  output logic       INC_START,
  output logic       INC_END,
  output logic       DEC_START,
  output logic       DEC_END,
  output logic       BUSY,
  output logic       ERR
);

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_CLR     = 3'd1,
    OP_LOAD    = 3'd2,
    OP_RUN_INC = 3'd3,
    OP_RUN_DEC = 3'd4,
    OP_HOLD    = 3'd5,
    OP_MODE    = 3'd6,
    OP_ILL     = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_RUN_WAIT,
    S_HOLD_WAIT
  } state_e;

  // Control FSM state. start_q marks the START cycle of a run.
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       start_q, start_d;
  op_e        op_q, op_d;
  logic [7:0] arg_q, arg_d;

  // Command source: the handshake directly, or the FIFO head.
  logic       src_valid;
  op_e        src_op;
  logic [7:0] src_arg;

  logic       done;      // FSM is in the last cycle of its command
  logic       can_take;  // FSM may start a new command at this edge
  logic       take;
  logic       ready_d;
  logic       busy_d;

  // True when a command's final output is produced at the next edge.
  function automatic logic is_last(input state_e st, input logic start,
                                   input logic [7:0] cnt);
    case (st)
      S_PULSE:     is_last = 1'b1;
      S_RUN_WAIT:  is_last = !start && (cnt == 8'd0);
      S_HOLD_WAIT: is_last = (cnt == 8'd1);
      default:     is_last = 1'b0;
    endcase
  endfunction

`ifdef COUNTER8_SEQ_FIFO_EN
  logic [10:0] fifo_mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count_q, count_d;
  logic        push;

  assign push      = CMD_VALID && CMD_READY;
  assign src_valid = (count_q != 3'd0);
  assign src_op    = op_e'(fifo_mem[rd_ptr][10:8]);
  assign src_arg   = fifo_mem[rd_ptr][7:0];
  // READY is low when full, so push and pop together never overflow.
  assign count_d   = count_q + 3'(push) - 3'(take);

  // NOTE: storage has no reset; only the pointers and count need one,
  // since an entry is never read before it has been written.
  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= {CMD_OP, CMD_ARG};
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      count_q <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (take) rd_ptr <= rd_ptr + 2'd1;
      count_q <= count_d;
    end
  end
`else
  assign src_valid = CMD_VALID && CMD_READY;
  assign src_op    = op_e'(CMD_OP);
  assign src_arg   = CMD_ARG;
`endif

  // NOTE: every variable gets a default at the top so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    op_d    = op_q;
    arg_d   = arg_q;

    done     = is_last(state_q, start_q, cnt_q);
    can_take = (state_q == S_IDLE) || done;
    take     = can_take && src_valid;

    if (state_q == S_RUN_WAIT) begin
      if (start_q)             start_d = 1'b0;
      else if (cnt_q != 8'd0)  cnt_d   = cnt_q - 8'd1;
    end
    if (state_q == S_HOLD_WAIT && !done) cnt_d = cnt_q - 8'd1;
    if (done) state_d = S_IDLE;

    if (take) begin
      op_d    = src_op;
      arg_d   = src_arg;
      cnt_d   = src_arg;
      start_d = 1'b0;
      case (src_op)
        OP_RUN_INC, OP_RUN_DEC: begin
          state_d = S_RUN_WAIT;
          start_d = 1'b1;
        end
        // HOLD with a zero count runs as an empty pulse.
        OP_HOLD: state_d = (src_arg != 8'd0) ? S_HOLD_WAIT : S_PULSE;
        default: state_d = S_PULSE;
      endcase
    end

`ifdef COUNTER8_SEQ_FIFO_EN
    ready_d = (count_d != 3'd4);
    busy_d  = (state_q != S_IDLE) || (count_q != 3'd0) || push;
`else
    // Ready whenever the FSM can take a command at the following edge.
    ready_d = (state_d == S_IDLE) || is_last(state_d, start_d, cnt_d);
    busy_d  = (state_q != S_IDLE);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      start_q <= 1'b0;
      op_q    <= OP_NOP;
      arg_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
    end
  end

  // Output registers: decode the FSM state one edge later.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      CMD_READY <= 1'b0;
      CLR       <= 1'b0;
      LOAD      <= 1'b0;
      DIN       <= 8'h00;
      HOLD      <= 1'b0;
      MODE_SEL  <= 1'b1;
      INC_START <= 1'b0;
      INC_END   <= 1'b0;
      DEC_START <= 1'b0;
      DEC_END   <= 1'b0;
      BUSY      <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      CMD_READY <= ready_d;
      CLR       <= (state_q == S_PULSE) && (op_q == OP_CLR);
      LOAD      <= (state_q == S_PULSE) && (op_q == OP_LOAD);
      if ((state_q == S_PULSE) && (op_q == OP_LOAD)) DIN <= arg_q;
      if ((state_q == S_PULSE) && (op_q == OP_MODE)) MODE_SEL <= arg_q[0];
      if ((state_q == S_PULSE) && (op_q == OP_ILL))  ERR <= 1'b1;
      HOLD      <= (state_q == S_HOLD_WAIT);
      INC_START <= (state_q == S_RUN_WAIT) && start_q && (op_q == OP_RUN_INC);
      INC_END   <= (state_q == S_RUN_WAIT) && done    && (op_q == OP_RUN_INC);
      DEC_START <= (state_q == S_RUN_WAIT) && start_q && (op_q == OP_RUN_DEC);
      DEC_END   <= (state_q == S_RUN_WAIT) && done    && (op_q == OP_RUN_DEC);
      BUSY      <= busy_d;
    end
  end

endmodule

// File: tb/tb_counter8_seq.sv
// tb_counter8_seq -- self-checking bench for counter8_seq.
//
// Each accepted command pushes its expected output events (strobe kind,
// absolute cycle, load data) into a scoreboard queue; a negedge monitor pops
// and compares every strobe/HOLD cycle the DUT produces. Directed steps also
// check reset values, DIN/MODE_SEL/ERR, BUSY length and CMD_READY.
// Build with COUNTER8_SEQ_FIFO_EN defined to exercise the FIFO variant.

module tb_counter8_seq;

`ifdef COUNTER8_SEQ_FIFO_EN
  localparam int  LAT      = 2;
  localparam int  BUSY_H0  = 3;     // BUSY also covers the queued cycle
  localparam logic RDY_RUN = 1'b1;  // FIFO not full while a run executes
`else
  localparam int  LAT      = 1;
  localparam int  BUSY_H0  = 1;
  localparam logic RDY_RUN = 1'b0;
`endif

  typedef enum int {EV_CLR, EV_LOAD, EV_INC_S, EV_INC_E,
                    EV_DEC_S, EV_DEC_E, EV_HOLD, EV_MULTI} ev_e;
  typedef struct {ev_e code; int cyc; logic [7:0] din;} ev_t;

  logic       CLK = 1'b0;
  logic       RESETn;
  logic       CMD_VALID, CMD_READY;
  logic [2:0] CMD_OP;
  logic [7:0] CMD_ARG;
  logic       CLR, LOAD, HOLD, MODE_SEL, INC_START, INC_END, DEC_START, DEC_END, BUSY, ERR;
  logic [7:0] DIN;

  counter8_seq dut (
    .CLK(CLK), .RESETn(RESETn), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_ARG(CMD_ARG), .CLR(CLR), .LOAD(LOAD), .DIN(DIN),
    .HOLD(HOLD), .MODE_SEL(MODE_SEL), .INC_START(INC_START), .INC_END(INC_END),
    .DEC_START(DEC_START), .DEC_END(DEC_END), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];
  int  e_prev = 0;   // cycle of the last expected output of the previous command
  int  last_s = 0;   // first output cycle of the most recent command
  logic [7:0] exp_din = 8'h00;
  logic       exp_mode = 1'b1;
  logic       exp_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, want, cyc);
      end
  endtask

  // Model: a command accepted at edge acc starts output at the later of
  // acc+LAT and the cycle after the previous command's last output.
  function automatic void push_exp(input logic [2:0] op, input logic [7:0] arg, input int acc);
    int s, e, a;
    a = int'(arg);
    s = (acc + LAT > e_prev + 1) ? acc + LAT : e_prev + 1;
    e = s;
    case (op)
      3'd1: exp_q.push_back('{EV_CLR, s, 8'h00});
      3'd2: begin exp_q.push_back('{EV_LOAD, s, arg}); exp_din = arg; end
      3'd3: begin
        exp_q.push_back('{EV_INC_S, s, 8'h00});
        exp_q.push_back('{EV_INC_E, s + a + 1, 8'h00});
        e = s + a + 1;
      end
      3'd4: begin
        exp_q.push_back('{EV_DEC_S, s, 8'h00});
        exp_q.push_back('{EV_DEC_E, s + a + 1, 8'h00});
        e = s + a + 1;
      end
      3'd5: begin
        for (int i = 0; i < a; i++) exp_q.push_back('{EV_HOLD, s + i, 8'h00});
        if (a != 0) e = s + a - 1;
      end
      3'd6: exp_mode = arg[0];
      3'd7: exp_err = 1'b1;
      default: ;
    endcase
    last_s = s;
    e_prev = e;
  endfunction

  // Monitor: every cycle with a strobe or HOLD must match the queue head.
  logic [6:0] ev_bits;
  ev_e        ev_code;
  ev_t        ev_head;
  always @(negedge CLK) begin
    if (RESETn === 1'b1) begin
      ev_bits = {CLR, LOAD, INC_START, INC_END, DEC_START, DEC_END, HOLD};
      if (ev_bits != 7'd0) begin
        case (ev_bits)
          7'b1000000: ev_code = EV_CLR;
          7'b0100000: ev_code = EV_LOAD;
          7'b0010000: ev_code = EV_INC_S;
          7'b0001000: ev_code = EV_INC_E;
          7'b0000100: ev_code = EV_DEC_S;
          7'b0000010: ev_code = EV_DEC_E;
          7'b0000001: ev_code = EV_HOLD;
          default:    ev_code = EV_MULTI;
        endcase
        checks++;
        assert (exp_q.size() != 0)
          else begin
            errors++;
            $error("FAIL unexpected_event: observed bits %b expected none (cycle %0d)", ev_bits, cyc);
          end
        if (exp_q.size() != 0) begin
          ev_head = exp_q.pop_front();
          check("event_kind", ev_code, ev_head.code);
          check("event_cycle", cyc, ev_head.cyc);
          if (ev_head.code == EV_LOAD) check("load_din", DIN, ev_head.din);
        end
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [7:0] arg, output int acc);
    int n;
    n = 0;
    @(negedge CLK);
    CMD_VALID = 1'b1;
    // While stalled, OP/ARG wander; only the accepted values count.
    while (CMD_READY !== 1'b1 && n < 200) begin
      CMD_OP  = 3'($urandom_range(7, 0));
      CMD_ARG = 8'($urandom);
      @(negedge CLK);
      n++;
    end
    CMD_OP  = op;
    CMD_ARG = arg;
    check("accept_ready", CMD_READY, 1'b1);
    acc = cyc + 1;
    push_exp(op, arg, acc);
    @(posedge CLK);
    #1 CMD_VALID = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cyc <= e_prev + 1) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  int acc, n_busy, s_first;

  initial begin
    RESETn    = 1'b0;
    CMD_VALID = 1'b0;
    CMD_OP    = 3'd0;
    CMD_ARG   = 8'h00;

    // Reset state.
    repeat (2) @(negedge CLK);
    check("rst_strobes", {CLR, LOAD, HOLD, INC_START, INC_END, DEC_START, DEC_END, BUSY, ERR}, 9'd0);
    check("rst_din", DIN, 8'h00);
    check("rst_mode", MODE_SEL, 1'b1);
    check("rst_ready", CMD_READY, 1'b0);
    RESETn = 1'b1;
    #1 check("ready_before_edge", CMD_READY, 1'b0);
    @(posedge CLK);
    #1 check("ready_after_edge", CMD_READY, 1'b1);
    check("idle_busy", BUSY, 1'b0);

    // LOAD then CLR back-to-back.
    send(3'd2, 8'h0A, acc);
    send(3'd1, 8'h00, acc);
    drain();
    check("din_held", DIN, exp_din);

    // Timed runs, including the zero-length run.
    send(3'd3, 8'd5, acc);
    send(3'd4, 8'd0, acc);
    drain();

    // HOLD for 2 cycles, then HOLD 0 with a BUSY length check.
    send(3'd5, 8'd2, acc);
    drain();
    send(3'd5, 8'd0, acc);
    n_busy = 0;
    repeat (8) begin
      @(negedge CLK);
      if (BUSY === 1'b1) n_busy++;
    end
    check("hold0_busy_cycles", n_busy, BUSY_H0);
    drain();

    // MODE, NOP, illegal opcode.
    send(3'd6, 8'h00, acc);
    send(3'd0, 8'hFF, acc);
    drain();
    check("mode_sel", MODE_SEL, exp_mode);
    check("err_before", ERR, exp_err);
    send(3'd7, 8'h00, acc);
    drain();
    check("err_set", ERR, exp_err);
    send(3'd2, 8'h5C, acc);
    send(3'd6, 8'h01, acc);
    drain();
    check("err_sticky", ERR, exp_err);
    check("din_5c", DIN, exp_din);
    check("mode_back", MODE_SEL, exp_mode);

    // READY during a run.
    send(3'd3, 8'd3, acc);
    check("ready_in_run", CMD_READY, RDY_RUN);
    drain();

`ifdef COUNTER8_SEQ_FIFO_EN
    // Fill the FIFO behind a long HOLD; the 5th waits for the first pop.
    send(3'd5, 8'd8, acc);
    send(3'd2, 8'h33, acc);
    s_first = last_s;
    send(3'd1, 8'h00, acc);
    send(3'd6, 8'h00, acc);
    send(3'd3, 8'd1, acc);
    check("ready_full", CMD_READY, 1'b0);
    send(3'd2, 8'h44, acc);
    check("fifth_accept_cycle", acc, s_first);
    drain();
    check("fifo_din", DIN, exp_din);
    check("fifo_mode", MODE_SEL, exp_mode);
`endif

    // Reset three cycles after START of a long run: END must never appear.
    send(3'd3, 8'd10, acc);
    n_busy = 0;
    while (cyc < last_s + 3 && n_busy < 100) begin
      @(negedge CLK);
      n_busy++;
    end
    check("run_started", exp_q.size(), 1);
    RESETn = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_outs", {CLR, LOAD, HOLD, INC_START, INC_END, DEC_START, DEC_END, BUSY, ERR, CMD_READY}, 10'd0);
    check("midrst_din", DIN, 8'h00);
    check("midrst_mode", MODE_SEL, 1'b1);
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    e_prev = cyc;
    repeat (15) @(negedge CLK);
    check("post_rst_busy", BUSY, 1'b0);
    check("post_rst_ready", CMD_READY, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
